// File: rtl/mac_vector_sequencer.sv
// mac_vector_sequencer: streams operand pairs into a MAC and feeds its result back as the next c,
// building acc = init +/- sum(a*b) with a one-cycle done pulse.
module mac_vector_sequencer #(
  parameter int size_mantissa = 24,
  parameter int size_exponent = 8,
  parameter int size_exception_field = 2,
  parameter int size = size_exponent + size_mantissa + size_exception_field,
  parameter int mac_latency = 0,
  parameter int size_len = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [size_len-1:0] length_i,
  input  logic [size-1:0]     init_i,
  input  logic                sub_i,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [size-1:0]     a_i,
  input  logic [size-1:0]     b_i,
  output logic [size-1:0]     mac_a_o,
  output logic [size-1:0]     mac_b_o,
  output logic [size-1:0]     mac_c_o,
  output logic                mac_sub_o,
  input  logic [size-1:0]     mac_result_i,
  output logic [size-1:0]     acc_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [size_len-1:0] count_o
);
  localparam int ww = (mac_latency > 0) ? $clog2(mac_latency + 1) : 1;
  typedef enum logic [1:0] {IDLE, ACCEPT, COMPUTE, DONE} state_t;
  state_t state_q, state_d;
  logic [size-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic [size_len-1:0] cnt_q, cnt_d;
  logic [ww-1:0] wait_q, wait_d;
  logic sub_q, sub_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      wait_q <= '0;
      sub_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      wait_q <= wait_d;
      sub_q <= sub_d;
    end
  end
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    wait_d = wait_q;
    sub_d = sub_q;
    in_ready = 1'b0;
    done_o = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        acc_d = init_i;
        sub_d = sub_i;
        cnt_d = length_i;
        state_d = (length_i == '0) ? DONE : ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d = a_i;
          b_d = b_i;
          wait_d = ww'(mac_latency);
          state_d = COMPUTE;
        end
      end
      // operands stay frozen here so a pipelined MAC sees a stable c for its whole latency
      COMPUTE: if (wait_q != '0) wait_d = wait_q - 1'b1;
      else begin
        acc_d = mac_result_i;
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == size_len'(1)) ? DONE : ACCEPT;
      end
      DONE: begin
        done_o = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  assign busy_o = state_q != IDLE;
  assign mac_a_o = a_q;
  assign mac_b_o = b_q;
  assign mac_c_o = acc_q;
  assign mac_sub_o = sub_q;
  assign acc_o = acc_q;
  assign count_o = cnt_q;
endmodule

// File: tb/tb_mac_vector_sequencer.sv
// tb_mac_vector_sequencer: random dot-product runs against a real-arithmetic model, plus a latency-2 stub MAC.
module tb_mac_vector_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;

  logic start0 = 0, sub0 = 0, v0 = 0, rdy0, ms0, busy0, done0;
  logic [15:0] len0 = 0, cnt0;
  logic [33:0] init0 = 0, a0 = 0, b0 = 0, ma0, mb0, mc0, res0, acc0;
  logic start2 = 0, sub2 = 0, v2 = 0, rdy2, ms2, busy2, done2;
  logic [15:0] len2 = 0, cnt2;
  logic [33:0] init2 = 0, a2 = 0, b2 = 0, ma2, mb2, mc2, res2, acc2, r1, r2;
  logic [33:0] pa[20], pb[20];

  mac_vector_sequencer u0 (.clk(clk), .rst(rst), .start(start0), .length_i(len0), .init_i(init0),
    .sub_i(sub0), .in_valid(v0), .in_ready(rdy0), .a_i(a0), .b_i(b0), .mac_a_o(ma0), .mac_b_o(mb0),
    .mac_c_o(mc0), .mac_sub_o(ms0), .mac_result_i(res0), .acc_o(acc0), .busy_o(busy0),
    .done_o(done0), .count_o(cnt0));
  mac_vector_sequencer #(.mac_latency(2)) u2 (.clk(clk), .rst(rst), .start(start2), .length_i(len2),
    .init_i(init2), .sub_i(sub2), .in_valid(v2), .in_ready(rdy2), .a_i(a2), .b_i(b2), .mac_a_o(ma2),
    .mac_b_o(mb2), .mac_c_o(mc2), .mac_sub_o(ms2), .mac_result_i(res2), .acc_o(acc2),
    .busy_o(busy2), .done_o(done2), .count_o(cnt2));

  function automatic real w2r(input logic [33:0] w);
    real m;
    int e;
    if (w[33:32] == 2'b00) return 0.0;
    m = 1.0 + real'(w[22:0]) / 8388608.0;
    e = int'(w[30:23]) - 127;
    for (int k = 0; k < e; k++) m = m * 2.0;
    for (int k = 0; k > e; k--) m = m / 2.0;
    return w[31] ? -m : m;
  endfunction

  function automatic logic [33:0] r2w(input real r);
    logic [63:0] d;
    if (r == 0.0) return '0;
    d = $realtobits(r);
    return {2'b01, d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic logic [33:0] iw(input int v);
    return r2w(real'(v));
  endfunction

  assign res0 = r2w(ms0 ? w2r(mc0) - w2r(ma0) * w2r(mb0) : w2r(mc0) + w2r(ma0) * w2r(mb0));
  always_ff @(posedge clk) begin
    r1 <= mc2 + 34'd1;
    r2 <= r1;
  end
  assign res2 = r2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: random in_valid, 1: always valid (latency checked), 2: always valid with a start poke mid-run
  task automatic run0(input int n, input logic [33:0] init, input bit sub, input int mode);
    real r;
    int i, t;
    bit dn;
    logic [15:0] cs[$];
    r = w2r(init);
    for (int k = 0; k < n; k++) r = sub ? r - w2r(pa[k]) * w2r(pb[k]) : r + w2r(pa[k]) * w2r(pb[k]);
    start0 = 1; len0 = 16'(n); init0 = init; sub0 = sub;
    @(negedge clk);
    start0 = 0;
    chk("busy_after_start", busy0, 1);
    i = 0; t = 0; dn = 0;
    while (!dn && t < 500) begin
      if (cs.size() == 0 || cs[$] != cnt0) cs.push_back(cnt0);
      if (done0) dn = 1;
      else begin
        a0 = pa[i]; b0 = pb[i];
        v0 = (mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        start0 = (mode == 2 && t == 1);
        if (mode == 2) len0 = 16'd5;
        if (rdy0 && v0) i++;
        @(negedge clk);
        t++;
      end
    end
    v0 = 0; start0 = 0;
    chk("done_seen", dn, 1);
    chk("pairs_used", i, n);
    chk("acc_final", acc0, r2w(r));
    chk("count_at_done", cnt0, 0);
    chk("ready_at_done", rdy0, 0);
    if (mode == 1) chk("ready_to_done_cycles", t, 2 * n);
    if (mode == 2) begin
      chk("count_steps", cs.size(), 3);
      if (cs.size() == 3) begin
        chk("count_seq0", cs[0], 2);
        chk("count_seq1", cs[1], 1);
        chk("count_seq2", cs[2], 0);
      end
    end
    @(negedge clk);
    chk("done_single_pulse", done0, 0);
    chk("idle_after_done", busy0, 0);
    chk("acc_hold_idle", acc0, r2w(r));
  endtask

  task automatic run2();
    int t, run, bad, used;
    logic [33:0] cp, ini;
    ini = {2'b01, 32'($urandom)};
    start2 = 1; len2 = 16'd3; init2 = ini;
    @(negedge clk);
    start2 = 0;
    t = 0; run = 0; bad = 0; used = 0; cp = '0;
    while (!done2 && t < 200) begin
      if (busy2 && !rdy2) begin
        if (run > 0 && mc2 !== cp) bad++;
        cp = mc2;
        run++;
      end else if (run > 0) begin
        chk("compute_cycles", run, 3);
        run = 0;
      end
      v2 = $urandom_range(0, 1) == 1;
      a2 = {2'b01, 32'($urandom)}; b2 = {2'b01, 32'($urandom)};
      if (rdy2 && v2) used++;
      @(negedge clk);
      t++;
    end
    v2 = 0;
    chk("lat_done_seen", done2, 1);
    chk("compute_cycles_last", run, 3);
    chk("mac_c_stable", bad, 0);
    chk("lat_pairs_used", used, 3);
    chk("lat_acc", acc2, ini + 34'd3);
    @(negedge clk);
    chk("lat_idle", busy2, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", rdy0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_acc", acc0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_mac_a", ma0, 0);
    chk("rst_mac_c", mc0, 0);
    chk("rst_busy2", busy2, 0);

    pa[0] = 34'h1_4000_0000; pb[0] = 34'h1_4040_0000;
    pa[1] = 34'h1_3F80_0000; pb[1] = 34'h1_3F80_0000;
    run0(2, 34'h1_3F80_0000, 0, 1);
    chk("basic_acc_8", acc0, 34'h1_4100_0000);

    run0(0, 34'h1_4248_0000, 0, 0);
    chk("zero_len_acc", acc0, 34'h1_4248_0000);

    for (int k = 0; k < 20; k++) begin
      pa[k] = iw($urandom_range(0, 8) - 4);
      pb[k] = iw($urandom_range(0, 8) - 4);
    end
    run0(2, iw($urandom_range(0, 20)), 0, 2);

    start0 = 1; len0 = 16'd4; init0 = iw(7);
    @(negedge clk);
    start0 = 0; v0 = 1;
    for (int j = 0; j < 3; j++) begin
      a0 = pa[j]; b0 = pb[j];
      @(negedge clk);
    end
    chk("mid_compute", busy0 && !rdy0, 1);
    rst = 1; v0 = 0;
    @(negedge clk);
    chk("midrst_busy", busy0, 0);
    chk("midrst_ready", rdy0, 0);
    chk("midrst_acc", acc0, 0);
    chk("midrst_count", cnt0, 0);
    chk("midrst_mac_b", mb0, 0);
    chk("midrst_sub", ms0, 0);
    rst = 0;
    run0(3, iw(11), 1, 0);

    repeat (6) begin
      for (int k = 0; k < 20; k++) begin
        pa[k] = iw($urandom_range(0, 8) - 4);
        pb[k] = iw($urandom_range(0, 8) - 4);
      end
      run0($urandom_range(1, 6), iw($urandom_range(0, 40) - 20), 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) run2();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
